// File: rtl/segway_auth_pkg.sv
// Shared types, defaults and the rider-authorisation transition function
// for the BLE command receiver.
package segway_auth_pkg;

  localparam int unsigned BAUD_DIV_DEF = 5208;
  localparam logic [7:0]  GO_CMD_DEF   = 8'h47;
  localparam logic [7:0]  STOP_CMD_DEF = 8'h53;
  localparam int unsigned BAUD_CNT_W   = 16;
  localparam int unsigned BIT_CNT_W    = 3;

  typedef enum logic [1:0] {
    AUTH_OFF  = 2'd0,
    AUTH_PWR1 = 2'd1,
    AUTH_PWR2 = 2'd2
  } auth_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Moves only on a received byte or a rider_off change; GO beats rider_off in PWR2.
  function automatic auth_state_t auth_next(input auth_state_t cur,
                                            input logic        rdy,
                                            input logic [7:0]  data,
                                            input logic        rider_off,
                                            input logic        rider_evt,
                                            input logic [7:0]  go_cmd,
                                            input logic [7:0]  stop_cmd);
    auth_state_t nxt;
    nxt = cur;
    if (rdy || rider_evt) begin
      case (cur)
        AUTH_OFF: begin
          if (rdy && (data == go_cmd)) nxt = AUTH_PWR1;
        end
        AUTH_PWR1: begin
          if (rdy && (data == stop_cmd)) nxt = rider_off ? AUTH_OFF : AUTH_PWR2;
        end
        AUTH_PWR2: begin
          if (rdy && (data == go_cmd)) nxt = AUTH_PWR1;
          else if (rider_off)          nxt = AUTH_OFF;
        end
        default: nxt = AUTH_OFF;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 LSB-first receiver: two-flop synchroniser, edge-history flop,
// mid-bit sampling from a reloading 16-bit down-counter.
module uart_rx_core
  import segway_auth_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       rx_rdy_o,
  output logic [7:0] rx_data_o,
  output logic       frm_err_o
);

  localparam logic [BAUD_CNT_W-1:0] HALF_RELOAD = BAUD_CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [BAUD_CNT_W-1:0] FULL_RELOAD = BAUD_CNT_W'(BAUD_DIV - 1);

  logic                  rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t             state_q;
  logic [BAUD_CNT_W-1:0] baud_cnt_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic [7:0]            shift_q;
  logic [7:0]            rx_data_q;
  logic                  rx_rdy_q, frm_err_q;

  logic baud_zero;
  assign baud_zero = (baud_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= RX_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_rdy_q   <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_rdy_q  <= 1'b0;
      frm_err_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          // Only a high-to-low transition starts a frame, so a break must release first.
          if (rx_prev_q && !rx_s2_q) begin
            baud_cnt_q <= HALF_RELOAD;
            state_q    <= RX_START;
          end
        end
        RX_START: begin
          if (!baud_zero) begin
            baud_cnt_q <= baud_cnt_q - BAUD_CNT_W'(1);
          end else if (rx_s2_q) begin
            state_q <= RX_IDLE;
          end else begin
            baud_cnt_q <= FULL_RELOAD;
            bit_cnt_q  <= '0;
            state_q    <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (!baud_zero) begin
            baud_cnt_q <= baud_cnt_q - BAUD_CNT_W'(1);
          end else begin
            shift_q    <= {rx_s2_q, shift_q[7:1]};
            baud_cnt_q <= FULL_RELOAD;
            bit_cnt_q  <= bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(7)) state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (!baud_zero) begin
            baud_cnt_q <= baud_cnt_q - BAUD_CNT_W'(1);
          end else begin
            if (rx_s2_q) begin
              rx_data_q <= shift_q;
              rx_rdy_q  <= 1'b1;
            end else begin
              frm_err_q <= 1'b1;
            end
            state_q <= RX_IDLE;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_rdy_o  = rx_rdy_q;
  assign rx_data_o = rx_data_q;
  assign frm_err_o = frm_err_q;

endmodule

// File: rtl/ble_auth_rx.sv
// BLE command receiver plus rider authorisation FSM that gates Segway power.
// Power drops only on STOP with no rider, or when the rider steps off in PWR2.
module ble_auth_rx
  import segway_auth_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF,
  parameter logic [7:0]  GO_CMD   = GO_CMD_DEF,
  parameter logic [7:0]  STOP_CMD = STOP_CMD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  output logic       frm_err,
  output logic [1:0] auth_state
);

  logic        core_rdy;
  logic [7:0]  core_data;
  logic        core_frm_err;

  uart_rx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (RX),
    .rx_rdy_o  (core_rdy),
    .rx_data_o (core_data),
    .frm_err_o (core_frm_err)
  );

  auth_state_t auth_q, auth_d;
  logic        rider_off_q;
  logic        pwr_up_q;

  always_comb begin
    auth_d = auth_next(auth_q, core_rdy, core_data, rider_off,
                       rider_off != rider_off_q, GO_CMD, STOP_CMD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      auth_q      <= AUTH_OFF;
      rider_off_q <= 1'b0;
      pwr_up_q    <= 1'b0;
    end else begin
      auth_q      <= auth_d;
      rider_off_q <= rider_off;
      pwr_up_q    <= (auth_d != AUTH_OFF);
    end
  end

  assign pwr_up     = pwr_up_q;
  assign rx_rdy     = core_rdy;
  assign rx_data    = core_data;
  assign frm_err    = core_frm_err;
  assign auth_state = auth_q;

endmodule

// File: tb/tb_ble_auth_rx.sv
// Self-checking bench for ble_auth_rx: UART frame driver, byte scoreboard,
// and directed auth-FSM scenarios.
module tb_ble_auth_rx;

  localparam int unsigned BD = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic       rider_off;
  logic       pwr_up;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       frm_err;
  logic [1:0] auth_state;

  ble_auth_rx #(
    .BAUD_DIV (BD),
    .GO_CMD   (8'h47),
    .STOP_CMD (8'h53)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (RX),
    .rider_off  (rider_off),
    .pwr_up     (pwr_up),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .frm_err    (frm_err),
    .auth_state (auth_state)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_q[$];
  int unsigned rdy_cnt = 0;
  int unsigned frm_cnt = 0;
  logic        post_pending = 1'b0;
  logic        pwr_pre, pwr_post;
  logic [1:0]  auth_post;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop expected byte on every rx_rdy and capture power around it.
  always @(negedge clk) begin
    if (post_pending) begin
      pwr_post     = pwr_up;
      auth_post    = auth_state;
      post_pending = 1'b0;
    end
    if (rx_rdy === 1'b1) begin
      rdy_cnt++;
      pwr_pre      = pwr_up;
      post_pending = 1'b1;
      if (exp_q.size() == 0) check_eq("rx_rdy_unexpected", 32'(rx_rdy), 32'd0);
      else                   check_eq("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
    if (frm_err === 1'b1) frm_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input bit good);
    int unsigned c0;
    c0 = rdy_cnt;
    if (good) exp_q.push_back(b);
    @(negedge clk);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = good;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("rdy_per_frame", rdy_cnt - c0, good ? 32'd1 : 32'd0);
  endtask

  initial begin
    #(2_000_000 * 10);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    rst = 1'b1; RX = 1'b1; rider_off = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_pwr_up", 32'(pwr_up), 32'd0);
    check_eq("rst_rx_rdy", 32'(rx_rdy), 32'd0);
    check_eq("rst_frm_err", 32'(frm_err), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_auth", 32'(auth_state), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // GO from OFF
    send_byte(8'h47, 1'b1);
    check_eq("t1_pwr_pre", 32'(pwr_pre), 32'd0);
    check_eq("t1_pwr_post", 32'(pwr_post), 32'd1);
    check_eq("t1_auth", 32'(auth_post), 32'd1);

    // STOP with rider on, then rider steps off
    send_byte(8'h53, 1'b1);
    check_eq("t2_pwr_post", 32'(pwr_post), 32'd1);
    check_eq("t2_auth", 32'(auth_post), 32'd2);
    rider_off = 1'b1;
    @(negedge clk);
    check_eq("t2_off_pwr", 32'(pwr_up), 32'd0);
    check_eq("t2_off_auth", 32'(auth_state), 32'd0);

    // Back to PWR2, then GO racing rider_off
    rider_off = 1'b0;
    send_byte(8'h47, 1'b1);
    send_byte(8'h53, 1'b1);
    check_eq("t3_pre_auth", 32'(auth_state), 32'd2);
    fork
      send_byte(8'h47, 1'b1);
      begin
        for (int i = 0; i < 12 * BD; i++) begin
          @(negedge clk);
          if (rx_rdy === 1'b1) begin
            rider_off = 1'b1;
            break;
          end
        end
      end
    join
    check_eq("t3_auth", 32'(auth_post), 32'd1);
    check_eq("t3_pwr_post", 32'(pwr_post), 32'd1);
    check_eq("t3_pwr_hold", 32'(pwr_up), 32'd1);

    // STOP in PWR1 with rider already off goes straight to OFF
    send_byte(8'h53, 1'b1);
    check_eq("t3b_pwr_pre", 32'(pwr_pre), 32'd1);
    check_eq("t3b_pwr_post", 32'(pwr_post), 32'd0);
    check_eq("t3b_auth", 32'(auth_post), 32'd0);

    // GO with a low stop bit
    send_byte(8'h47, 1'b0);
    check_eq("t4_frm_cnt", frm_cnt, 32'd1);
    check_eq("t4_rx_data", 32'(rx_data), 32'h53);
    check_eq("t4_pwr", 32'(pwr_up), 32'd0);

    // Short low glitch, then a non-command byte
    c0 = rdy_cnt;
    @(negedge clk);
    RX = 1'b0;
    repeat (BD / 2 - 20) @(negedge clk);
    RX = 1'b1;
    repeat (2 * BD) @(negedge clk);
    check_eq("t5_glitch_rdy", rdy_cnt - c0, 32'd0);
    check_eq("t5_glitch_frm", frm_cnt, 32'd1);
    send_byte(8'h41, 1'b1);
    check_eq("t5_auth", 32'(auth_post), 32'd0);
    check_eq("t5_pwr", 32'(pwr_post), 32'd0);

    // Reset mid-frame while powered
    rider_off = 1'b0;
    send_byte(8'h47, 1'b1);
    check_eq("t6_pwr_on", 32'(pwr_up), 32'd1);
    c0 = rdy_cnt;
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      RX = i[0] ? 1'b1 : 1'b1;
      repeat (BD) @(negedge clk);
    end
    RX = 1'b0;
    repeat (BD / 2) @(negedge clk);
    rst = 1'b1;
    RX  = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_pwr", 32'(pwr_up), 32'd0);
    check_eq("t6_rst_auth", 32'(auth_state), 32'd0);
    check_eq("t6_rst_data", 32'(rx_data), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BD) @(negedge clk);
    check_eq("t6_no_rdy", rdy_cnt - c0, 32'd0);
    send_byte(8'h47, 1'b1);
    check_eq("t6_pwr_post", 32'(pwr_post), 32'd1);
    check_eq("t6_auth", 32'(auth_post), 32'd1);

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    check_eq("frm_total", frm_cnt, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
